// File: rtl/scan_controller.sv
// rtl/scan_controller.sv - 4-digit display scan sequencer with anode dead-time and per-digit blanking
module scan_controller #(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] blank_mask,
  output logic [3:0] select,
  output logic [3:0] an_n,
  output logic [1:0] slot,
  output logic       frame_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    select_d, mask_q, mask_d, an_n_d;
  logic [1:0]    slot_d;
  logic          tick_d;

  always_comb begin
    cnt_d    = cnt;
    select_d = select;
    slot_d   = slot;
    mask_d   = mask_q;
    tick_d   = 1'b0;
    if (enable) begin
      if (cnt == LAST) begin
        cnt_d    = '0;
        select_d = {select[2:0], select[3]};
        slot_d   = slot + 2'd1;
        mask_d   = blank_mask;
        tick_d   = select[3];
      end else begin
        cnt_d = cnt + CW'(1);
      end
    end
    // Anode decision uses next-state values so it lines up with select/cnt on the same edge
    if (!enable || (cnt_d < BLANK) || mask_d[slot_d])
      an_n_d = 4'hF;
    else
      an_n_d = ~select_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      select     <= 4'b0001;
      slot       <= 2'd0;
      mask_q     <= 4'b0000;
      an_n       <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      select     <= select_d;
      slot       <= slot_d;
      mask_q     <= mask_d;
      an_n       <= an_n_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_scan_controller.sv
// tb/tb_scan_controller.sv - scoreboard bench for scan_controller (PRESCALE=8, BLANK_CYCLES=2)
module tb_scan_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] blank_mask = 4'b0000;
  logic [3:0] select, an_n;
  logic [1:0] slot;
  logic       frame_tick;

  scan_controller #(.PRESCALE(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .blank_mask(blank_mask),
    .select(select), .an_n(an_n), .slot(slot), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] an;
    logic [1:0] slt;
    logic       tick;
    string      tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Behavioural reference: position within frame plus sampled mask
  int         m_cnt, m_slot;
  logic [3:0] m_mask, m_an;
  logic       m_tick;

  function automatic logic [3:0] onehot(input int s);
    logic [3:0] v;
    v = 4'b0001 << s;
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_slot = 0; m_mask = 4'b0000; m_an = 4'hF; m_tick = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [3:0] mask);
    m_tick = 1'b0;
    if (en) begin
      if (m_cnt == 7) begin
        m_tick = (m_slot == 3);
        m_cnt  = 0;
        m_slot = (m_slot + 1) % 4;
        m_mask = mask;
      end else begin
        m_cnt = m_cnt + 1;
      end
      m_an = (m_cnt < 2 || m_mask[m_slot]) ? 4'hF : ~onehot(m_slot);
    end else begin
      m_an = 4'hF;
    end
  endtask

  task automatic push(input logic [3:0] s, input logic [3:0] a, input logic [1:0] sl,
                      input logic t, input string tag);
    exp_t e;
    e.sel = s; e.an = a; e.slt = sl; e.tick = t; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic cyc(input logic en, input logic [3:0] mask, input string tag);
    enable = en; blank_mask = mask;
    model_step(en, mask);
    push(onehot(m_slot), m_an, 2'(m_slot), m_tick, tag);
    @(negedge clk);
  endtask

  task automatic cyc_lit(input logic en, input logic [3:0] mask, input logic [3:0] s,
                         input logic [3:0] a, input logic [1:0] sl, input logic t,
                         input string tag);
    enable = en; blank_mask = mask;
    model_step(en, mask);
    push(s, a, sl, t, tag);
    @(negedge clk);
  endtask

  task automatic run_to(input logic [3:0] mask, input int s, input int c, input string tag);
    int guard = 0;
    while (!(m_slot == s && m_cnt == c) && guard < 64) begin
      cyc(1'b1, mask, tag);
      guard++;
    end
  endtask

  // Monitor: the DUT output is live every edge and on async reset assertion
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({select, an_n, slot, frame_tick} !== {e.sel, e.an, e.slt, e.tick}) begin
          failures++;
          $display("FAIL %s t=%0t got sel=%b an_n=%b slot=%0d tick=%b exp sel=%b an_n=%b slot=%0d tick=%b",
                   e.tag, $time, select, an_n, slot, frame_tick, e.sel, e.an, e.slt, e.tick);
        end
      end
    end
  end

  initial begin
    model_reset();
    #2;
    push(4'b0001, 4'hF, 2'd0, 1'b0, "reset_async");
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    cyc_lit(1'b1, 4'b0000, 4'b0001, 4'hF, 2'd0, 1'b0, "first_edge");
    cyc_lit(1'b1, 4'b0000, 4'b0001, 4'b1110, 2'd0, 1'b0, "first_on");
    for (int i = 0; i < 94; i++) cyc(1'b1, 4'b0000, "scan_frames");

    cyc(1'b1, 4'b0000, "blank_pre");
    cyc(1'b1, 4'b0000, "blank_pre");
    run_to(4'b0100, 2, 3, "blank_slot2");
    run_to(4'b1000, 3, 3, "blank_mid2");
    run_to(4'b0000, 0, 2, "blank_slot3");

    run_to(4'b0000, 1, 5, "pause_pre");
    for (int i = 0; i < 10; i++) cyc(1'b0, 4'b0000, "pause_hold");
    cyc_lit(1'b1, 4'b0000, 4'b0010, 4'b1101, 2'd1, 1'b0, "resume_on");
    cyc(1'b1, 4'b0000, "resume_cnt7");
    cyc_lit(1'b1, 4'b0000, 4'b0100, 4'hF, 2'd2, 1'b0, "resume_adv");

    run_to(4'b0000, 3, 7, "collide_pre");
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0000, "collide_hold");
    cyc_lit(1'b1, 4'b0000, 4'b0001, 4'hF, 2'd0, 1'b1, "collide_tick");
    cyc_lit(1'b1, 4'b0000, 4'b0001, 4'hF, 2'd0, 1'b0, "collide_after");

    run_to(4'b0000, 3, 5, "midreset_pre");
    @(posedge clk);
    #2;
    push(4'b0001, 4'hF, 2'd0, 1'b0, "reset_midrun");
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc_lit(1'b1, 4'b0000, 4'b0001, 4'hF, 2'd0, 1'b0, "rerelease");
    for (int i = 0; i < 40; i++) cyc(1'b1, 4'b0000, "post_reset");

    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_controller.md
# scan_controller

Digit-scan sequencer that drives the 4-digit multiplexed 7-segment display. It sits directly upstream of `seg_multiplexer` and generates the one-hot `select` that picks which nibble (`A`–`D`) is decoded. It also generates the matching active-low anode drive, with a dead-time gap between digits to prevent ghosting. It supports per-digit blanking and emits a once-per-frame tick for display-data update logic.

## Interface

- `PRESCALE`, default 1000: clk cycles per digit slot; legal range ≥ 2.
- `BLANK_CYCLES`, default 16: dead-time cycles at the start of each slot, with all anodes off; legal range 0 ≤ BLANK_CYCLES < PRESCALE.

- `clk`  input  1: system clock, all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `enable`  input  1: 1 = scanning runs; 0 = scan frozen and display dark.
- `blank_mask`  input  4: bit i = 1 keeps digit i dark during its slot; bit 0 ↔ select 0001.
- `select`  output  4: one-hot digit select to `seg_multiplexer.select`, registered.
- `an_n`  output  4: active-low anode drive, registered.
- `slot`  output  2: binary index of the active digit (0–3), registered.
- `frame_tick`  output  1: one-cycle pulse at each wrap from digit 3 to digit 0, registered.

## Operation

- **Prescaler.**
  - Counter `cnt` with width $clog2(PRESCALE), counting 0..PRESCALE-1.
  - Increments each cycle while `enable`=1.
  - At PRESCALE-1 it wraps to 0 and the slot advances.
- **Slot advance.**
  - `select` rotates left: 0001→0010→0100→1000→0001.
  - `slot` increments modulo 4 and always equals log2(`select`).
- **Invariant.** `select` is always exactly one-hot. It is never 0000 and never multi-hot, including during enable=0.
- **Mask sampling.** `blank_mask` is sampled into an internal register on every slot advance. Changes take effect at the next slot boundary, never mid-slot.
- **Anode drive.**
  - `an_n` = 1111 when `enable`=0.
  - `an_n` = 1111 when `cnt` < BLANK_CYCLES.
  - `an_n` = 1111 when the masked bit for the current slot is 1.
  - Otherwise `an_n` = ~`select`.
  - `an_n` is computed from next-state values, so it is cycle-aligned with `select`/`cnt`.
- **frame_tick.** Asserted for exactly the first cycle in which `select` = 0001 after 1000. It is not asserted after reset release.
- **enable=0.**
  - `cnt`, `select`, `slot` and the mask register all hold.
  - `an_n` goes to 1111 on the next edge.
  - `frame_tick` = 0.
- **enable 0→1.**
  - Counting resumes from the held `cnt`.
  - The slot completes its remaining cycles. There is no restart of the dead-time.
  - If the held `cnt` ≥ BLANK_CYCLES, the anode turns on at the first enabled edge.
- **BLANK_CYCLES=0.** There is no dead-time; the anode is on for the full slot.

## Timing

- **Reset values (asynchronous, immediately on `rst_n`=0).**
  - `cnt`=0
  - `select`=0001
  - `slot`=0
  - `an_n`=1111
  - `frame_tick`=0
  - mask register=0000
- **After reset release with enable=1.**
  - First edge: `cnt`=1.
  - Slot 0 lasts PRESCALE cycles counted from release.
- **Slot change.** On the edge where `cnt`=PRESCALE-1, the next `select`/`slot` are visible after that edge, `cnt`=0, and `an_n`=1111 (when BLANK_CYCLES>0).
- **Anode timing.**
  - Anode on-time per slot = PRESCALE − BLANK_CYCLES cycles.
  - Frame period = 4·PRESCALE cycles of enabled time.
- **Mid-operation reset.** Reset mid-slot or mid-frame forces reset values at once. No partial slot is completed.
- **Enable and slot boundary in the same cycle.** If `enable` falls in the same cycle that `cnt`=PRESCALE-1, enable wins: there is no advance and `cnt` holds at PRESCALE-1. The advance occurs at the first enabled edge after re-enable.
- **Downstream latency.** `seg_multiplexer` sees `select` with zero added latency from this block's register. `an_n` and `select` change on the same edge.

## Test plan

All scenarios use PRESCALE=8 and BLANK_CYCLES=2.

- **Reset.** Drive `rst_n`=0 mid-run (slot 3, cnt=5) → within the same cycle `select`=0001, `slot`=0, `an_n`=1111, `frame_tick`=0, asynchronously without a clock edge.
- **Basic scan.** Release reset with enable=1, blank_mask=0000 →
  - `select`=0001 for 8 cycles, `an_n`=1111 for 2 cycles then 1110 for 6 cycles;
  - then `select`=0010 with `an_n` 1111×2, 1101×6;
  - continuing through 0100/1011 and 1000/0111.
- **Frame tick.** Run 3 full frames → `frame_tick` high for exactly one cycle every 32 cycles, coincident with the first `select`=0001 after 1000, and never on the first slot after reset.
- **Blanking.** Set blank_mask=0100 mid-slot 0 →
  - slot 1 shows `an_n` 1101 normally;
  - slot 2 has `select`=0100 but `an_n`=1111 for all 8 cycles;
  - changing the mask mid-slot 2 has no effect until slot 3.
- **Enable pause.** Drop enable when cnt=5 in slot 1 and hold low 10 cycles →
  - `an_n`=1111 from the next edge, and `select`=0010 and `cnt`=5 held;
  - after re-enable, `an_n`=1101 on the first edge, and the slot ends after 2 more cycles (cnt 6, 7) then advances to 0100.
- **Boundary collision.** Drop enable exactly when cnt=7 in slot 3 → no advance and no `frame_tick`; on re-enable the next edge gives `select`=0001 with `frame_tick`=1.
